stopwatch_ctrl_fsm: RTL and testbench

//  Run-control sequencer for the stopwatch.
//  - Turns three raw push-buttons into clean one-cycle command pulses.
//  - Runs a Moore FSM whose state drives the time counter's 2-bit cnt_ctrl (IDLE/COUNT/PAUSE).
//  - Generates a lap-hold flag that freezes the segment display while counting continues.
//  - Sits between the board keys and the time counter / segment decoder.

---
 rtl/stopwatch_ctrl_fsm_pkg.sv | 21 ++
 rtl/stopwatch_ctrl_fsm_key_debounce.sv | 48 ++++
 rtl/stopwatch_ctrl_fsm.sv | 94 +++++++++
 tb/tb_stopwatch_ctrl_fsm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_ctrl_fsm_pkg.sv
// Shared definitions for the stopwatch run-control block.
//  st_e          : run state, and also the cnt_ctrl encoding seen by the time counter
//  *_DEF         : default debounce window (10 ms at 50 MHz) and counter width
//  K_RUN/CLR/LAP : index of each key in the packed key/pulse vectors
package stopwatch_ctrl_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_PAUSE = 2'b10
  } st_e;

  localparam int DEBOUNCE_CNT_DEF = 500000;
  localparam int DB_W_DEF         = 19;

  localparam int NUM_KEYS = 3;
  localparam int K_RUN    = 0;
  localparam int K_CLR    = 1;
  localparam int K_LAP    = 2;

endpackage

// File: rtl/stopwatch_ctrl_fsm_key_debounce.sv
// key_debounce: one raw active-low push-button -> one-cycle press pulse.
//  clk      in  system clock
//  rst_n    in  async active-low reset (key treated as released)
//  key_n    in  raw key, active-low, asynchronous to clk
//  press_p  out one-cycle pulse when the debounced level goes 1->0
// Key edge to pulse latency is 2 (sync) + DEBOUNCE_CNT cycles.
module key_debounce #(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int DB_W         = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_p
);

  logic [1:0]      r_sync;
  logic            r_stable;
  logic [DB_W-1:0] r_cnt;
  logic            r_press;

  // The counter measures how long the synced level has disagreed with the
  // accepted level. Any agreement (a bounce back) restarts the window, so only
  // a level held for DEBOUNCE_CNT consecutive cycles is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_W'(DEBOUNCE_CNT - 1)) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
        r_press  <= ~r_sync[1];   // pulse on press only, never on release
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign press_p = r_press;

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// stopwatch_ctrl_fsm: run-control sequencer for the stopwatch.
//  clk        in  50 MHz system clock
//  rst_n      in  async active-low reset
//  key_run_n  in  raw start/stop key (active-low, async)
//  key_clr_n  in  raw clear key (active-low, async)
//  key_lap_n  in  raw lap key (active-low, async)
//  cnt_ctrl   out time counter control: 00 IDLE, 01 COUNT, 10 PAUSE
//  lap_hold   out 1 = display freezes while counting continues
//  running    out 1 while in COUNT
// Moore FSM: all outputs are decodes of registers, so they change on the
// clock edge after the key pulse.
module stopwatch_ctrl_fsm
  import stopwatch_ctrl_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
  parameter int DB_W         = DB_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_run_n,
  input  logic       key_clr_n,
  input  logic       key_lap_n,
  output logic [1:0] cnt_ctrl,
  output logic       lap_hold,
  output logic       running
);

  logic [NUM_KEYS-1:0] w_key_n;
  logic [NUM_KEYS-1:0] w_press;
  logic                w_run_p, w_clr_p, w_lap_p;

  assign w_key_n = {key_lap_n, key_clr_n, key_run_n};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .DB_W         (DB_W)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_n   (w_key_n[k]),
      .press_p (w_press[k])
    );
  end

  assign w_run_p = w_press[K_RUN];
  assign w_clr_p = w_press[K_CLR];
  assign w_lap_p = w_press[K_LAP];

  st_e  r_state, w_state_nxt;
  logic r_lap_hold, w_lap_nxt;

  // state + lap_hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lap_hold <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lap_hold <= w_lap_nxt;
    end
  end

  // next-state; lap acts independently of the run/clr transition in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_lap_nxt   = r_lap_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_run_p) w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (w_lap_p) w_lap_nxt   = ~r_lap_hold;
        if (w_run_p) w_state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (w_lap_p) w_lap_nxt = 1'b0;
        // clear wins over a simultaneous start
        if (w_clr_p)      w_state_nxt = ST_IDLE;
        else if (w_run_p) w_state_nxt = ST_COUNT;
      end
      default: w_state_nxt = ST_IDLE;   // 2'b11 recovers
    endcase
    if (w_state_nxt == ST_IDLE) w_lap_nxt = 1'b0;
  end

  // Moore outputs
  always_comb begin
    cnt_ctrl = r_state;
    running  = (r_state == ST_COUNT);
    lap_hold = r_lap_hold;
  end

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Directed + random bench for stopwatch_ctrl_fsm with a short debounce window.
module tb_stopwatch_ctrl_fsm;

  localparam int DBC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_run_n = 1'b1, key_clr_n = 1'b1, key_lap_n = 1'b1;
  logic [1:0] cnt_ctrl;
  logic       lap_hold, running;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_fsm #(.DEBOUNCE_CNT(DBC), .DB_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_run_n (key_run_n),
    .key_clr_n (key_clr_n),
    .key_lap_n (key_lap_n),
    .cnt_ctrl  (cnt_ctrl),
    .lap_hold  (lap_hold),
    .running   (running)
  );

  // Reference model. Keys index 0 run, 1 clr, 2 lap.
  // A raw level becomes visible two cycles later; the accepted level flips
  // once the visible level has disagreed with it for DBC consecutive cycles.
  logic [2:0] m_d1, m_d2, m_stable, m_press;
  int         m_run [3];
  int         m_mode;          // 0 idle, 1 count, 2 pause
  logic       m_lap;

  task automatic model_reset();
    m_d1 = '1; m_d2 = '1; m_stable = '1; m_press = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_mode = 0; m_lap = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] p;
    p = m_press;
    case (m_mode)
      0: if (p[0]) m_mode = 1;
      1: begin
        if (p[2]) m_lap = !m_lap;
        if (p[0]) m_mode = 2;
      end
      default: begin
        if (p[2]) m_lap = 1'b0;
        if (p[1]) m_mode = 0;
        else if (p[0]) m_mode = 1;
      end
    endcase
    if (m_mode == 0) m_lap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_press[i] = 1'b0;
      if (m_d2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DBC) begin
          m_stable[i] = m_d2[i];
          m_run[i]    = 0;
          m_press[i]  = (m_d2[i] == 1'b0);
        end
      end else begin
        m_run[i] = 0;
      end
      m_d2[i] = m_d1[i];
      m_d1[i] = raw[i];
    end
  endtask

  function automatic logic [1:0] exp_ctrl();
    return (m_mode == 1) ? 2'b01 : (m_mode == 2) ? 2'b10 : 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cnt_ctrl"}, cnt_ctrl, exp_ctrl());
    chk({tag, ".lap_hold"}, {1'b0, lap_hold}, {1'b0, m_lap});
    chk({tag, ".running"},  {1'b0, running},  {1'b0, (m_mode == 1)});
  endtask

  // one clock: drive keys (bit0 run, bit1 clr, bit2 lap; 1 = released)
  task automatic cyc(input logic [2:0] keys, input string tag);
    key_run_n = keys[0]; key_clr_n = keys[1]; key_lap_n = keys[2];
    @(posedge clk);
    model_edge(keys);
    #1;
    chk_model(tag);
  endtask

  // press the keys in mask for 8 cycles, then release for 8
  task automatic press(input logic [2:0] mask, input string tag);
    for (int i = 0; i < 8; i++) cyc(~mask, tag);
    for (int i = 0; i < 8; i++) cyc(3'b111, tag);
  endtask

  initial begin
    logic [2:0] keys;
    model_reset();

    // 1. reset state, before any clock edge and while held
    #1;
    chk("rst.cnt_ctrl", cnt_ctrl, 2'b00);
    chk("rst.lap_hold", {1'b0, lap_hold}, 2'b00);
    chk("rst.running",  {1'b0, running},  2'b00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(3'b111, "idle");
    chk("idle20", cnt_ctrl, 2'b00);

    // 2. run held 10 cycles: pulse after 6, cnt_ctrl moves on the 7th edge
    for (int i = 1; i <= 10; i++) begin
      cyc(3'b110, "runhold");
      if (i == 6) chk("run_lat6", cnt_ctrl, 2'b00);
      if (i == 7) chk("run_lat7", cnt_ctrl, 2'b01);
    end
    chk("run_held", cnt_ctrl, 2'b01);
    for (int i = 0; i < 10; i++) cyc(3'b111, "runrel");
    chk("run_release", cnt_ctrl, 2'b01);

    // 3. chatter: toggle every 2 cycles for 12 cycles, then held
    for (int i = 0; i < 12; i++) cyc((((i / 2) % 2) != 0) ? 3'b111 : 3'b110, "chatter");
    chk("chatter_nopulse", cnt_ctrl, 2'b01);
    for (int i = 1; i <= 10; i++) begin
      cyc(3'b110, "chathold");
      if (i == 6) chk("chat_lat6", cnt_ctrl, 2'b01);
      if (i == 7) chk("chat_lat7", cnt_ctrl, 2'b10);
    end
    for (int i = 0; i < 8; i++) cyc(3'b111, "chatrel");

    // 4. run/run/clr sequence; clr ignored while counting
    press(3'b010, "clr0");  chk("seq_clr_pause", cnt_ctrl, 2'b00);
    press(3'b001, "seq1");  chk("seq_run1", cnt_ctrl, 2'b01);
    press(3'b001, "seq2");  chk("seq_run2", cnt_ctrl, 2'b10);
    press(3'b010, "seq3");  chk("seq_clr", cnt_ctrl, 2'b00);
    press(3'b001, "seq4");
    press(3'b010, "seq5");  chk("clr_in_count", cnt_ctrl, 2'b01);

    // 5. lap toggling in COUNT, then run + clr clears lap_hold
    press(3'b100, "lap1");  chk("lap1", {1'b0, lap_hold}, 2'b01);
    press(3'b100, "lap2");  chk("lap2", {1'b0, lap_hold}, 2'b00);
    press(3'b100, "lap3");  chk("lap3", {1'b0, lap_hold}, 2'b01);
    press(3'b001, "lapr");  chk("lap_pause", {1'b0, lap_hold}, 2'b01);
    press(3'b010, "lapc");
    chk("lap_clr.cnt", cnt_ctrl, 2'b00);
    chk("lap_clr.hold", {1'b0, lap_hold}, 2'b00);

    // lap together with run in COUNT: both act
    press(3'b001, "lrA");
    press(3'b101, "lrB");
    chk("lap_run.cnt", cnt_ctrl, 2'b10);
    chk("lap_run.hold", {1'b0, lap_hold}, 2'b01);

    // 6. run + clr together in PAUSE -> IDLE
    press(3'b011, "runclr");
    chk("runclr", cnt_ctrl, 2'b00);

    // async reset mid-COUNT, no clock edge involved
    press(3'b001, "pre_rst");
    chk("pre_rst", cnt_ctrl, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.cnt_ctrl", cnt_ctrl, 2'b00);
    chk("arst.lap_hold", {1'b0, lap_hold}, 2'b00);
    chk("arst.running",  {1'b0, running},  2'b00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_model("post_rst");

    // random key activity; each key toggles with probability 1/8 per cycle
    keys = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(7, 0) == 0) keys[k] = ~keys[k];
      cyc(keys, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
